ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack for the single-cycle CPU's subroutine call/return support.
- Sits upstream of the PC register. On a call, it stores the return address (PC+1 from the PC adder). On a return, it supplies the top entry to the next-PC mux.
- Circular LIFO with combinational top-of-stack read, clocked push/pop, and sticky overflow/underflow flags that software can inspect and clear.

Parameters:
- WIDTH, 10, address width in bits; matches the PC width.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- push  input  1  call: store din on this rising edge.
- pop  input  1  return: discard top on this rising edge.
- din  input  WIDTH  return address to push (PC+1).
- clr_err  input  1  synchronous clear of both sticky error flags.
- dout  output  WIDTH  current top entry; combinational.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CW  number of valid entries, 0..DEPTH.
- overflow  output  1  sticky: a push was made while full.
- underflow  output  1  sticky: a pop was made while empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, independent of clk):
  - top pointer=0, count=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, dout=0.
  - Storage array is not reset.
  - Reset asserted mid-operation aborts any pending push/pop. The first edge after release sees an empty stack.
- Storage: DEPTH x WIDTH array, circular, indexed by top pointer tp (log2(DEPTH) bits, wraps modulo DEPTH).
- Read path: dout = mem[tp] when count != 0, else 0. Purely combinational, zero latency, so the PC mux can use it in the same cycle as the return instruction.
- Push only (push=1, pop=0), on the rising edge:
  - tp <= tp+1 (wraps); mem[tp+1] <= din.
  - count < DEPTH: count <= count+1.
  - count == DEPTH: count stays DEPTH; oldest entry is overwritten by wrap; overflow <= 1.
- Pop only (push=0, pop=1), on the rising edge:
  - count != 0: tp <= tp-1 (wraps); count <= count-1.
  - count == 0: no pointer/count change; underflow <= 1; dout stays 0.
- Push and pop together (call in the same cycle as a return):
  - count != 0: replace top, i.e. mem[tp] <= din; tp and count unchanged; no flag change. dout shows the old top in this cycle.
  - count == 0: underflow <= 1; then din is pushed; count <= 1; tp <= tp+1.
- Neither asserted: hold all state.
- Flags:
  - overflow and underflow stay set until clr_err=1 at a rising edge, or until reset.
  - If clr_err coincides with a new error event, the new event wins and the flag reads 1 after the edge.
- Arithmetic: all pointer arithmetic is unsigned modulo DEPTH. count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then push 0x005, 0x012, 0x3FF on three edges -> count=3, dout=0x3FF. Pop x3 -> dout sequence 0x012, 0x005, 0 (empty=1); no flags set.
- DEPTH=8: push 1..9 (values 0x001..0x009) -> after 8th push full=1, overflow=0. After 9th push count=8, overflow=1, dout=0x009. Eight pops return 0x008..0x002, then empty=1. The 0x001 entry is lost.
- Empty stack, pop -> underflow=1, count=0, dout=0. Next edge with clr_err=1 -> underflow=0. clr_err and pop-while-empty in the same edge -> underflow=1.
- Stack holding 0x020 (count=1): push=1, pop=1, din=0x040 -> dout=0x020 during the cycle; after the edge dout=0x040, count=1, no flags. Same stimulus on an empty stack -> underflow=1, count=1, dout=0x040.
- Push 4 entries, then pull reset low between clock edges -> count=0, dout=0, empty=1, flags=0 immediately, without waiting for a clock edge. After reset is released, a single push of 0x0AA -> count=1, dout=0x0AA.

Source files
------------

// File: rtl/ret_addr_stack_if.sv
// Bus between the CPU call/return logic (master) and the return-address stack (slave).
// clk and reset stay plain ports on the stack itself.
interface ret_addr_stack_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) ();
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din, clr_err,
        input  dout, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, din, clr_err,
        output dout, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Circular LIFO of return addresses with a combinational top-of-stack read
// and sticky overflow/underflow flags.
module ret_addr_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    ret_addr_stack_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] tp_reg, tp_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          empty_w;
    logic          full_w;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == CW'(DEPTH));

    always_comb begin
        tp_next        = tp_reg;
        count_next     = count_reg;
        overflow_next  = bus.clr_err ? 1'b0 : overflow_reg;
        underflow_next = bus.clr_err ? 1'b0 : underflow_reg;
        wr_en          = 1'b0;
        wr_addr        = tp_reg + 1'b1;
        case ({bus.push, bus.pop})
            2'b10: begin
                tp_next = tp_reg + 1'b1;
                wr_en   = 1'b1;
                // When full the pointer still advances, overwriting the oldest entry.
                if (full_w) overflow_next = 1'b1;
                else        count_next    = count_reg + 1'b1;
            end
            2'b01: begin
                if (empty_w) begin
                    underflow_next = 1'b1;
                end else begin
                    tp_next    = tp_reg - 1'b1;
                    count_next = count_reg - 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty_w) begin
                    underflow_next = 1'b1;
                    tp_next        = tp_reg + 1'b1;
                    count_next     = CW'(1);
                end else begin
                    wr_addr = tp_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tp_reg        <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            tp_reg        <= tp_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is not reset: a slot only becomes visible after a push writes it,
    // so a stray write while reset is low can never be observed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.din;
    end

    assign bus.dout      = empty_w ? '0 : mem[tp_reg];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed bench for ret_addr_stack: each task drives one scenario and checks inline.
`timescale 1ns/1ps
module tb_ret_addr_stack;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    ret_addr_stack_if #(.WIDTH(10), .DEPTH(8)) bus ();

    ret_addr_stack #(.WIDTH(10), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus, sample 1 ns after the edge, then idle the inputs.
    task automatic step(input logic p, input logic q, input logic [9:0] d, input logic c);
        bus.push = p; bus.pop = q; bus.din = d; bus.clr_err = c;
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full: got %b/%b want 1/0", bus.empty, bus.full); end
        n_cmp++; if (bus.dout !== 10'h000) begin n_err++; $display("FAIL reset_dout: got %h want 000", bus.dout); end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b/%b want 0/0", bus.overflow, bus.underflow); end
        // A push held during reset must be ignored.
        bus.push = 1'b1; bus.din = 10'h155;
        @(posedge clk); #1;
        bus.push = 1'b0; bus.din = '0;
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_hold_push: got count %0d want 0", bus.count); end
        @(negedge clk); reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_push_pop();
        step(1, 0, 10'h005, 0);
        step(1, 0, 10'h012, 0);
        step(1, 0, 10'h3FF, 0);
        n_cmp++; if (bus.count !== 4'd3 || bus.dout !== 10'h3FF) begin n_err++; $display("FAIL push3: got count %0d dout %h want 3 3ff", bus.count, bus.dout); end
        step(0, 1, 10'h000, 0);
        n_cmp++; if (bus.dout !== 10'h012) begin n_err++; $display("FAIL pop1: got %h want 012", bus.dout); end
        step(0, 1, 10'h000, 0);
        n_cmp++; if (bus.dout !== 10'h005) begin n_err++; $display("FAIL pop2: got %h want 005", bus.dout); end
        step(0, 1, 10'h000, 0);
        n_cmp++; if (bus.dout !== 10'h000 || bus.empty !== 1'b1) begin n_err++; $display("FAIL pop3: got dout %h empty %b want 000 1", bus.dout, bus.empty); end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL pushpop_flags: got %b/%b want 0/0", bus.overflow, bus.underflow); end
        $display("test_push_pop done");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 10'(i), 0);
            if (i == 8) begin
                n_cmp++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL push8: got full %b ovf %b want 1 0", bus.full, bus.overflow); end
            end
        end
        n_cmp++; if (bus.count !== 4'd8 || bus.overflow !== 1'b1 || bus.dout !== 10'h009) begin n_err++; $display("FAIL push9: got count %0d ovf %b dout %h want 8 1 009", bus.count, bus.overflow, bus.dout); end
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 10'h000, 0);
            n_cmp++;
            if (bus.dout !== ((k < 8) ? 10'(9 - k) : 10'h000)) begin
                n_err++; $display("FAIL ovf_pop%0d: got %h want %h", k, bus.dout, (k < 8) ? 10'(9 - k) : 10'h000);
            end
        end
        n_cmp++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got empty %b unf %b want 1 0", bus.empty, bus.underflow); end
        step(0, 0, 10'h000, 1);
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_underflow();
        step(0, 1, 10'h000, 0);
        n_cmp++; if (bus.underflow !== 1'b1 || bus.count !== 4'd0 || bus.dout !== 10'h000) begin n_err++; $display("FAIL unf_set: got unf %b count %0d dout %h want 1 0 000", bus.underflow, bus.count, bus.dout); end
        step(0, 0, 10'h000, 0);
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b want 1", bus.underflow); end
        step(0, 0, 10'h000, 1);
        n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", bus.underflow); end
        step(0, 1, 10'h000, 1);
        n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL unf_clr_race: got %b want 1", bus.underflow); end
        step(0, 0, 10'h000, 1);
        $display("test_underflow done");
    endtask

    task automatic test_back_to_back();
        step(1, 0, 10'h020, 0);
        bus.push = 1'b1; bus.pop = 1'b1; bus.din = 10'h040;
        #1;
        n_cmp++; if (bus.dout !== 10'h020) begin n_err++; $display("FAIL replace_pre: got %h want 020", bus.dout); end
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0;
        n_cmp++; if (bus.dout !== 10'h040 || bus.count !== 4'd1) begin n_err++; $display("FAIL replace_post: got dout %h count %0d want 040 1", bus.dout, bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin n_err++; $display("FAIL replace_flags: got %b/%b want 0/0", bus.overflow, bus.underflow); end
        step(0, 1, 10'h000, 0);
        step(1, 1, 10'h040, 0);
        n_cmp++; if (bus.underflow !== 1'b1 || bus.count !== 4'd1 || bus.dout !== 10'h040) begin n_err++; $display("FAIL pushpop_empty: got unf %b count %0d dout %h want 1 1 040", bus.underflow, bus.count, bus.dout); end
        step(0, 1, 10'h000, 1);
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        step(0, 1, 10'h000, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 10'(10'h100 + i), 0);
        n_cmp++; if (bus.count !== 4'd4 || bus.underflow !== 1'b1) begin n_err++; $display("FAIL pre_reset: got count %0d unf %b want 4 1", bus.count, bus.underflow); end
        #2; reset = 1'b0; #1;
        n_cmp++; if (bus.count !== 4'd0 || bus.dout !== 10'h000 || bus.empty !== 1'b1) begin n_err++; $display("FAIL async_reset: got count %0d dout %h empty %b want 0 000 1", bus.count, bus.dout, bus.empty); end
        n_cmp++; if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL async_reset_flags: got %b/%b want 0/0", bus.overflow, bus.underflow); end
        @(negedge clk); reset = 1'b1;
        step(1, 0, 10'h0AA, 0);
        n_cmp++; if (bus.count !== 4'd1 || bus.dout !== 10'h0AA) begin n_err++; $display("FAIL post_reset_push: got count %0d dout %h want 1 0aa", bus.count, bus.dout); end
        $display("test_async_reset done");
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.clr_err = 1'b0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
